// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared widths and port indices for the register-file writeback arbiter
//
// Purpose : common constants used by rf_wb_arbiter and rf_scoreboard.
// Contents: REG_AW   register address width
//           REG_DW   register data width
//           NUM_REGS architectural register count (r0 hard-wired to zero)
//           PORT0/1  writeback port indices, also the encoding of the round-robin pointer

package rf_pkg;

    localparam int REG_AW   = 5;
    localparam int REG_DW   = 32;
    localparam int NUM_REGS = 32;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // One-hot decode of a register address; r0 never appears in any mask.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] addr);
        logic [NUM_REGS-1:0] mask;
        mask       = '0;
        mask[addr] = 1'b1;
        mask[0]    = 1'b0;
        return mask;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - 32-entry pending-write scoreboard with three read taps
//
// Purpose : tracks registers that have an issued but not yet committed write.
// Ports   : clk, rst_n         clock, async active-low reset
//           set_en, set_addr   issue of an instruction that will write set_addr
//           clr_en, clr_addr   commit of a write to clr_addr (register file updated)
//           tap_a/b/c_addr     read addresses
//           tap_a/b/c          pending bit at each read address (combinational, no bypass)
//           err                sticky: an issue hit an already pending register

module rf_scoreboard
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_addr,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_addr,
    input  logic [REG_AW-1:0] tap_a_addr,
    input  logic [REG_AW-1:0] tap_b_addr,
    input  logic [REG_AW-1:0] tap_c_addr,
    output logic              tap_a,
    output logic              tap_b,
    output logic              tap_c,
    output logic              err
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] pending_next;
    logic                err_next;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) begin
            set_mask = reg_onehot(set_addr);
        end
        if (clr_en) begin
            clr_mask = reg_onehot(clr_addr);
        end
        // Clear first, then set: an issue landing on the commit cycle of the
        // same register must leave the bit set for the new writer.
        pending_next = (pending & ~clr_mask) | set_mask;
        // A re-issue to a pending register is a protocol violation by the issuer.
        err_next     = err | (set_en & pending[set_addr]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            err     <= 1'b0;
        end else begin
            pending <= pending_next;
            err     <= err_next;
        end
    end

    assign tap_a = pending[tap_a_addr];
    assign tap_b = pending[tap_b_addr];
    assign tap_c = pending[tap_c_addr];

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - two-port register-file writeback arbiter with pending-write scoreboard
//
// Purpose : shares the single register-file write port between the ALU writeback (port 0)
//           and the load / multi-cycle writeback (port 1), and exposes RAW/WAW hazard taps.
// Ports   : clk, rst_n                  clock, async active-low reset
//           wb0_valid/addr/data/ready   port 0 request, ready = granted this cycle
//           wb1_valid/addr/data/ready   port 1 request, ready = granted this cycle
//           iss_valid, iss_addr         issue of an instruction that will write iss_addr
//           chk_addr_a/b, hz_a/b        source hazard checks
//           iss_busy                    destination already pending; issuer must hold
//           rf_we/rf_waddr/rf_wdata     registered register-file write port
//           sb_err                      sticky scoreboard violation flag
// Params  : RR_MODE       1 = round-robin, 0 = fixed priority with port 0 favoured
//           STARVE_LIMIT  fixed-priority losses of port 1 before it is forced to win (1..15)

module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int RR_MODE      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb0_valid,
    input  logic [REG_AW-1:0] wb0_addr,
    input  logic [REG_DW-1:0] wb0_data,
    output logic              wb0_ready,
    input  logic              wb1_valid,
    input  logic [REG_AW-1:0] wb1_addr,
    input  logic [REG_DW-1:0] wb1_data,
    output logic              wb1_ready,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_addr,
    input  logic [REG_AW-1:0] chk_addr_a,
    input  logic [REG_AW-1:0] chk_addr_b,
    output logic              hz_a,
    output logic              hz_b,
    output logic              iss_busy,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [REG_DW-1:0] rf_wdata,
    output logic              sb_err
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic              rr_ptr;
    logic [3:0]        starve_cnt;
    logic              gnt0;
    logic              gnt1;
    logic              any_gnt;
    logic              pick1;
    logic [REG_AW-1:0] sel_addr;
    logic [REG_DW-1:0] sel_data;
    logic [3:0]        starve_next;

    // Grant selection. Contention is the only case that needs a policy; a lone
    // requester is always granted so writeback never stalls needlessly.
    always_comb begin
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        pick1 = 1'b0;
        if (wb0_valid && wb1_valid) begin
            if (RR_MODE != 0) begin
                pick1 = (rr_ptr == PORT0);
            end else begin
                pick1 = (starve_cnt == STARVE_MAX);
            end
        end else begin
            pick1 = wb1_valid;
        end
        // Gating on rst_n keeps both readys low while reset is asserted.
        if (rst_n) begin
            gnt1 = wb1_valid & pick1;
            gnt0 = wb0_valid & ~pick1;
        end
    end

    assign wb0_ready = gnt0;
    assign wb1_ready = gnt1;
    assign any_gnt   = gnt0 | gnt1;
    assign sel_addr  = gnt1 ? wb1_addr : wb0_addr;
    assign sel_data  = gnt1 ? wb1_data : wb0_data;

    // Port 1 loses only under contention; the count saturates so it can never wrap
    // past the forcing threshold even if the limit is set to the maximum.
    always_comb begin
        starve_next = 4'd0;
        if (wb1_valid && !gnt1) begin
            starve_next = (starve_cnt == 4'hF) ? starve_cnt : starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= PORT0;
            starve_cnt <= 4'd0;
        end else begin
            starve_cnt <= starve_next;
            if (any_gnt) begin
                rr_ptr <= gnt1;
            end
        end
    end

    // Output stage. A granted write to r0 is accepted but never reaches the
    // register file, and leaves the last committed address/data in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= 1'b0;
            if (any_gnt && (sel_addr != '0)) begin
                rf_we    <= 1'b1;
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
            end
        end
    end

    // Commit clears the bit at the edge that ends the rf_we cycle, so hazards
    // drop exactly when the register file holds the new value.
    rf_scoreboard u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en     (iss_valid),
        .set_addr   (iss_addr),
        .clr_en     (rf_we),
        .clr_addr   (rf_waddr),
        .tap_a_addr (chk_addr_a),
        .tap_b_addr (chk_addr_b),
        .tap_c_addr (iss_addr),
        .tap_a      (hz_a),
        .tap_b      (hz_b),
        .tap_c      (iss_busy),
        .err        (sb_err)
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter (round-robin and fixed-priority instances)

module tb_rf_wb_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        wb0_valid [2];
    logic [4:0]  wb0_addr  [2];
    logic [31:0] wb0_data  [2];
    logic        wb0_ready [2];
    logic        wb1_valid [2];
    logic [4:0]  wb1_addr  [2];
    logic [31:0] wb1_data  [2];
    logic        wb1_ready [2];
    logic        iss_valid [2];
    logic [4:0]  iss_addr  [2];
    logic [4:0]  chk_addr_a[2];
    logic [4:0]  chk_addr_b[2];
    logic        hz_a      [2];
    logic        hz_b      [2];
    logic        iss_busy  [2];
    logic        rf_we     [2];
    logic [4:0]  rf_waddr  [2];
    logic [31:0] rf_wdata  [2];
    logic        sb_err    [2];

    // Instance 0: round-robin. Instance 1: fixed priority, starve limit 4.
    rf_wb_arbiter #(.RR_MODE(1), .STARVE_LIMIT(4)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .wb0_valid(wb0_valid[0]), .wb0_addr(wb0_addr[0]), .wb0_data(wb0_data[0]), .wb0_ready(wb0_ready[0]),
        .wb1_valid(wb1_valid[0]), .wb1_addr(wb1_addr[0]), .wb1_data(wb1_data[0]), .wb1_ready(wb1_ready[0]),
        .iss_valid(iss_valid[0]), .iss_addr(iss_addr[0]),
        .chk_addr_a(chk_addr_a[0]), .chk_addr_b(chk_addr_b[0]),
        .hz_a(hz_a[0]), .hz_b(hz_b[0]), .iss_busy(iss_busy[0]),
        .rf_we(rf_we[0]), .rf_waddr(rf_waddr[0]), .rf_wdata(rf_wdata[0]), .sb_err(sb_err[0])
    );

    rf_wb_arbiter #(.RR_MODE(0), .STARVE_LIMIT(4)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .wb0_valid(wb0_valid[1]), .wb0_addr(wb0_addr[1]), .wb0_data(wb0_data[1]), .wb0_ready(wb0_ready[1]),
        .wb1_valid(wb1_valid[1]), .wb1_addr(wb1_addr[1]), .wb1_data(wb1_data[1]), .wb1_ready(wb1_ready[1]),
        .iss_valid(iss_valid[1]), .iss_addr(iss_addr[1]),
        .chk_addr_a(chk_addr_a[1]), .chk_addr_b(chk_addr_b[1]),
        .hz_a(hz_a[1]), .hz_b(hz_b[1]), .iss_busy(iss_busy[1]),
        .rf_we(rf_we[1]), .rf_waddr(rf_waddr[1]), .rf_wdata(rf_wdata[1]), .sb_err(sb_err[1])
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a set of pending register numbers, the last committed write,
    // which port won the most recent grant, and how many cycles in a row port 1 has lost.
    bit          m_pend [2][32];
    bit          m_we   [2];
    logic [4:0]  m_waddr[2];
    logic [31:0] m_wdata[2];
    bit          m_err  [2];
    int          m_last [2];
    int          m_lose [2];
    int          cur_g  [2];
    int          obs_g  [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 32; r++) m_pend[i][r] = 1'b0;
            m_we[i] = 1'b0; m_waddr[i] = '0; m_wdata[i] = '0; m_err[i] = 1'b0;
            m_last[i] = 0; m_lose[i] = 0;
        end
    endtask

    // -1 = no grant, otherwise the winning port number.
    function automatic int model_grant(input int i);
        if (!rst_n) return -1;
        if (wb0_valid[i] && !wb1_valid[i]) return 0;
        if (!wb0_valid[i] && wb1_valid[i]) return 1;
        if (!wb0_valid[i] && !wb1_valid[i]) return -1;
        if (i == 0) return (m_last[i] == 0) ? 1 : 0;
        return (m_lose[i] >= 4) ? 1 : 0;
    endfunction

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            cur_g[i] = model_grant(i);
            obs_g[i] = wb1_ready[i] ? 1 : (wb0_ready[i] ? 0 : -1);
            check($sformatf("ready0[%0d]", i), 32'(wb0_ready[i]), 32'(cur_g[i] == 0));
            check($sformatf("ready1[%0d]", i), 32'(wb1_ready[i]), 32'(cur_g[i] == 1));
            check($sformatf("hz_a[%0d]", i), 32'(hz_a[i]), 32'(m_pend[i][chk_addr_a[i]]));
            check($sformatf("hz_b[%0d]", i), 32'(hz_b[i]), 32'(m_pend[i][chk_addr_b[i]]));
            check($sformatf("iss_busy[%0d]", i), 32'(iss_busy[i]), 32'(m_pend[i][iss_addr[i]]));
            check($sformatf("rf_we[%0d]", i), 32'(rf_we[i]), 32'(m_we[i]));
            if (m_we[i]) begin
                check($sformatf("rf_waddr[%0d]", i), 32'(rf_waddr[i]), 32'(m_waddr[i]));
                check($sformatf("rf_wdata[%0d]", i), rf_wdata[i], m_wdata[i]);
            end
            check($sformatf("sb_err[%0d]", i), 32'(sb_err[i]), 32'(m_err[i]));
        end
    endtask

    task automatic model_update();
        int          g;
        logic [4:0]  a;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            g = cur_g[i];
            if (iss_valid[i] && m_pend[i][iss_addr[i]]) m_err[i] = 1'b1;
            if (m_we[i]) m_pend[i][m_waddr[i]] = 1'b0;
            if (iss_valid[i] && iss_addr[i] != 0) m_pend[i][iss_addr[i]] = 1'b1;
            m_we[i] = 1'b0;
            if (g >= 0) begin
                a = (g == 1) ? wb1_addr[i] : wb0_addr[i];
                if (a != 0) begin
                    m_we[i]    = 1'b1;
                    m_waddr[i] = a;
                    m_wdata[i] = (g == 1) ? wb1_data[i] : wb0_data[i];
                end
                m_last[i] = g;
            end
            m_lose[i] = (wb1_valid[i] && g != 1) ? m_lose[i] + 1 : 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drv_wb(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                          input bit v1, input logic [4:0] a1, input logic [31:0] d1);
        for (int i = 0; i < 2; i++) begin
            wb0_valid[i] = v0; wb0_addr[i] = a0; wb0_data[i] = d0;
            wb1_valid[i] = v1; wb1_addr[i] = a1; wb1_data[i] = d1;
        end
    endtask

    task automatic drv_iss(input bit v, input logic [4:0] a, input logic [4:0] ca, input logic [4:0] cb);
        for (int i = 0; i < 2; i++) begin
            iss_valid[i] = v; iss_addr[i] = a; chk_addr_a[i] = ca; chk_addr_b[i] = cb;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drv_wb(0, 0, 0, 0, 0, 0);
        drv_iss(0, 0, 0, 0);
        model_reset();
        step();
        step();
        rst_n = 1'b1;
    endtask

    int exp_rr [6] = '{1, 0, 1, 0, 1, 0};
    int exp_fp [6] = '{0, 0, 0, 0, 1, 0};

    initial begin
        rst_n = 1'b0;
        drv_wb(0, 0, 0, 0, 0, 0);
        drv_iss(0, 0, 0, 0);
        model_reset();
        #1;
        do_reset();

        // Port 0 alone writes r5.
        drv_wb(1, 5, 32'hDEADBEEF, 0, 0, 0);
        step();
        check("r5_ready", 32'(obs_g[0]), 32'd0);
        drv_wb(0, 0, 0, 0, 0, 0);
        check("r5_we", 32'(rf_we[0]), 32'd1);
        check("r5_waddr", 32'(rf_waddr[0]), 32'd5);
        check("r5_wdata", rf_wdata[0], 32'hDEADBEEF);
        step();

        // Continuous contention: fresh data each cycle, both ports always valid.
        for (int c = 0; c < 6; c++) begin
            drv_wb(1, 5'd1, 32'h100 + 32'(c), 1, 5'd2, 32'h200 + 32'(c));
            step();
            check($sformatf("rr_seq%0d", c), 32'(obs_g[0]), 32'(exp_rr[c]));
            check($sformatf("fp_seq%0d", c), 32'(obs_g[1]), 32'(exp_fp[c]));
            check($sformatf("one_hot%0d", c), 32'(wb0_ready[0] & wb1_ready[0]), 32'd0);
        end
        drv_wb(0, 0, 0, 0, 0, 0);
        step();

        // r0: granted but never written; issue to r0 never marks pending.
        drv_wb(1, 0, 32'h1234, 0, 0, 0);
        drv_iss(1, 0, 0, 0);
        step();
        check("r0_ready", 32'(obs_g[0]), 32'd0);
        drv_wb(0, 0, 0, 0, 0, 0);
        drv_iss(0, 0, 0, 0);
        check("r0_we", 32'(rf_we[0]), 32'd0);
        check("r0_hz", 32'(hz_a[0]), 32'd0);
        step();

        // Double issue of r3 raises sticky sb_err.
        drv_iss(1, 3, 3, 0);
        step();
        check("r3_err0", 32'(sb_err[0]), 32'd0);
        step();
        drv_iss(0, 0, 3, 0);
        check("r3_err1", 32'(sb_err[0]), 32'd1);
        step();
        step();
        check("r3_err_hold", 32'(sb_err[0]), 32'd1);

        // Reset asserted while a grant is pending: everything drops at once.
        drv_wb(1, 9, 32'hCAFE0009, 0, 0, 0);
        @(negedge clk);
        check("mid_ready_pre", 32'(wb0_ready[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_ready", 32'(wb0_ready[0]), 32'd0);
        check("mid_hz", 32'(hz_a[0]), 32'd0);
        check("mid_err", 32'(sb_err[0]), 32'd0);
        check("mid_we", 32'(rf_we[1]), 32'd0);
        @(posedge clk);
        #1;
        model_reset();
        drv_wb(0, 0, 0, 0, 0, 0);
        check("mid_lost", 32'(rf_we[0]), 32'd0);
        rst_n = 1'b1;
        step();

        // Hazard on r7: held until the commit cycle, gone the next.
        drv_iss(1, 7, 7, 0);
        step();
        drv_iss(0, 0, 7, 0);
        drv_wb(0, 0, 0, 1, 7, 32'h77);
        step();
        drv_wb(0, 0, 0, 0, 0, 0);
        check("r7_hz_commit", 32'(hz_a[0] & rf_we[0]), 32'd1);
        step();
        check("r7_hz_clear", 32'(hz_a[0]), 32'd0);
        // Issue r7 in its own commit cycle: bit must survive.
        drv_iss(1, 7, 7, 0);
        step();
        drv_iss(0, 0, 7, 0);
        drv_wb(0, 0, 0, 1, 7, 32'h78);
        step();
        drv_wb(0, 0, 0, 0, 0, 0);
        drv_iss(1, 7, 7, 0);
        step();
        drv_iss(0, 0, 7, 0);
        check("r7_set_wins", 32'(hz_a[0]), 32'd1);
        step();

        // Randomized traffic; requesters hold until granted.
        for (int c = 0; c < 3000; c++) begin
            if (c % 750 == 0) do_reset();
            for (int i = 0; i < 2; i++) begin
                if (!wb0_valid[i] || cur_g[i] == 0) begin
                    wb0_valid[i] = ($urandom_range(0, 2) != 0);
                    wb0_addr[i]  = 5'($urandom_range(0, 9));
                    wb0_data[i]  = $urandom;
                end
                if (!wb1_valid[i] || cur_g[i] == 1) begin
                    wb1_valid[i] = ($urandom_range(0, 2) != 0);
                    wb1_addr[i]  = 5'($urandom_range(0, 9));
                    wb1_data[i]  = $urandom;
                end
                iss_valid[i]  = ($urandom_range(0, 3) == 0);
                iss_addr[i]   = 5'($urandom_range(0, 9));
                chk_addr_a[i] = 5'($urandom_range(0, 9));
                chk_addr_b[i] = 5'($urandom_range(0, 31));
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
